// File: rtl/sdm_seq_ctrl.sv
// sdm_seq_ctrl: start-up and update sequencer for a 3-stage MASH sigma-delta
// modulator. The sequencer buffers one fractional word behind a valid/ready
// handshake. On enable it holds the modulator in clear with zero input, then
// releases the clear and waits for the pipeline to settle. In steady state it
// applies each new word on a single clean clock edge. All outputs are
// registered except cfg_ready, which is a direct function of the pending flop.
module sdm_seq_ctrl #(
    parameter int W          = 10,
    parameter int FLUSH_CYC  = 8,
    parameter int SETTLE_CYC = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_frac,
    output logic         cfg_ready,
    output logic [W-1:0] sdm_din,
    output logic         sdm_clr_n,
    output logic         sdm_out_valid,
    output logic         upd_pulse,
    output logic [7:0]   upd_cnt,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    localparam logic [7:0] FLUSH_INIT  = 8'(FLUSH_CYC - 1);
    localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYC - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic           r_pending;
    logic           w_pending_nxt;
    logic [W-1:0]   r_shadow;
    logic [W-1:0]   w_shadow_nxt;
    logic [W-1:0]   r_act_frac;
    logic [W-1:0]   w_act_frac_nxt;
    logic [W-1:0]   r_din;
    logic [W-1:0]   w_din_nxt;
    logic           r_clr_n;
    logic           w_clr_n_nxt;
    logic           r_out_valid;
    logic           w_out_valid_nxt;
    logic           r_upd_pulse;
    logic           w_upd_pulse_nxt;
    logic [7:0]     r_upd_cnt;
    logic [7:0]     w_upd_cnt_nxt;
    logic           w_accept;

    // The shadow register is free whenever nothing is pending.
    assign cfg_ready = ~r_pending;
    assign w_accept  = cfg_valid & ~r_pending;

    assign sdm_din       = r_din;
    assign sdm_clr_n     = r_clr_n;
    assign sdm_out_valid = r_out_valid;
    assign upd_pulse     = r_upd_pulse;
    assign upd_cnt       = r_upd_cnt;
    assign state         = r_state;

    // Next-state and next-output logic: handshake capture, then FSM sequencing.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pending_nxt   = r_pending;
        w_shadow_nxt    = r_shadow;
        w_act_frac_nxt  = r_act_frac;
        w_din_nxt       = r_din;
        w_clr_n_nxt     = r_clr_n;
        w_out_valid_nxt = r_out_valid;
        w_upd_pulse_nxt = 1'b0;
        w_upd_cnt_nxt   = r_upd_cnt;

        // Accept and apply are mutually exclusive: accept needs pending=0,
        // apply needs pending=1, so the case below never fights this capture.
        if (w_accept) begin
            w_shadow_nxt  = cfg_frac;
            w_pending_nxt = 1'b1;
        end else begin
            w_shadow_nxt  = r_shadow;
        end

        case (r_state)
            ST_IDLE: begin
                w_clr_n_nxt     = 1'b0;
                w_din_nxt       = {W{1'b0}};
                w_out_valid_nxt = 1'b0;
                if (en) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = FLUSH_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end

            ST_FLUSH: begin
                if (!en) begin
                    w_state_nxt     = ST_IDLE;
                    w_clr_n_nxt     = 1'b0;
                    w_din_nxt       = {W{1'b0}};
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = 8'd0;
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    // Release clear and present the first word on the same edge.
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = SETTLE_INIT;
                    w_clr_n_nxt = 1'b1;
                    if (r_pending) begin
                        w_din_nxt       = r_shadow;
                        w_act_frac_nxt  = r_shadow;
                        w_pending_nxt   = 1'b0;
                        w_upd_pulse_nxt = 1'b1;
                        w_upd_cnt_nxt   = r_upd_cnt + 8'd1;
                    end else begin
                        w_din_nxt = r_act_frac;
                    end
                end
            end

            ST_SETTLE: begin
                // Words accepted here stay pending until RUN.
                if (!en) begin
                    w_state_nxt     = ST_IDLE;
                    w_clr_n_nxt     = 1'b0;
                    w_din_nxt       = {W{1'b0}};
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = 8'd0;
                end else if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else begin
                    w_state_nxt     = ST_RUN;
                    w_out_valid_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                // Disable has priority over an apply; the word stays pending.
                if (!en) begin
                    w_state_nxt     = ST_IDLE;
                    w_clr_n_nxt     = 1'b0;
                    w_din_nxt       = {W{1'b0}};
                    w_out_valid_nxt = 1'b0;
                    w_cnt_nxt       = 8'd0;
                end else if (r_pending) begin
                    w_din_nxt       = r_shadow;
                    w_act_frac_nxt  = r_shadow;
                    w_pending_nxt   = 1'b0;
                    w_upd_pulse_nxt = 1'b1;
                    w_upd_cnt_nxt   = r_upd_cnt + 8'd1;
                end else begin
                    w_din_nxt = r_din;
                end
            end

            default: begin
                w_state_nxt     = ST_IDLE;
                w_clr_n_nxt     = 1'b0;
                w_din_nxt       = {W{1'b0}};
                w_out_valid_nxt = 1'b0;
                w_cnt_nxt       = 8'd0;
            end
        endcase
    end

    // State, counter, handshake and registered output flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_pending   <= 1'b0;
            r_shadow    <= {W{1'b0}};
            r_act_frac  <= {W{1'b0}};
            r_din       <= {W{1'b0}};
            r_clr_n     <= 1'b0;
            r_out_valid <= 1'b0;
            r_upd_pulse <= 1'b0;
            r_upd_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pending   <= w_pending_nxt;
            r_shadow    <= w_shadow_nxt;
            r_act_frac  <= w_act_frac_nxt;
            r_din       <= w_din_nxt;
            r_clr_n     <= w_clr_n_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_upd_pulse <= w_upd_pulse_nxt;
            r_upd_cnt   <= w_upd_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sdm_seq_ctrl.sv
// Directed self-checking bench for sdm_seq_ctrl (W=10, FLUSH=8, SETTLE=4).
module tb_sdm_seq_ctrl;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       cfg_valid;
    logic [9:0] cfg_frac;
    logic       cfg_ready;
    logic [9:0] sdm_din;
    logic       sdm_clr_n;
    logic       sdm_out_valid;
    logic       upd_pulse;
    logic [7:0] upd_cnt;
    logic [1:0] state;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    logic [7:0] exp_cnt;
    logic [9:0] exp_q[$];
    logic [9:0] exp_word;
    int         n_acc;
    int         n_app;

    sdm_seq_ctrl #(.W(10), .FLUSH_CYC(8), .SETTLE_CYC(4)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .en            (en),
        .cfg_valid     (cfg_valid),
        .cfg_frac      (cfg_frac),
        .cfg_ready     (cfg_ready),
        .sdm_din       (sdm_din),
        .sdm_clr_n     (sdm_clr_n),
        .sdm_out_valid (sdm_out_valid),
        .upd_pulse     (upd_pulse),
        .upd_cnt       (upd_cnt),
        .state         (state)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one word for one edge (shadow must be free).
    task automatic offer(input logic [9:0] w);
        cfg_valid = 1'b1;
        cfg_frac  = w;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_frac  = 10'h000;
        exp_cnt   = 8'd0;
        ticks(3);

        // Reset values
        check("rst_state", 32'(state), 32'd0);
        check("rst_clr_n", 32'(sdm_clr_n), 32'd0);
        check("rst_din", 32'(sdm_din), 32'd0);
        check("rst_valid", 32'(sdm_out_valid), 32'd0);
        check("rst_pulse", 32'(upd_pulse), 32'd0);
        check("rst_updcnt", 32'(upd_cnt), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        rstn = 1'b1;
        tick();

        // Word accepted in IDLE, then enable and start-up timing
        offer(10'h155);
        check("idle_acc_ready", 32'(cfg_ready), 32'd0);
        check("idle_acc_state", 32'(state), 32'd0);
        en = 1'b1;
        tick();                                   // edge k
        check("k_state", 32'(state), 32'd1);
        ticks(7);                                 // edge k+7
        check("k7_clr_n", 32'(sdm_clr_n), 32'd0);
        check("k7_din", 32'(sdm_din), 32'd0);
        check("k7_state", 32'(state), 32'd1);
        tick();                                   // edge k+8
        exp_cnt = exp_cnt + 8'd1;
        check("k8_clr_n", 32'(sdm_clr_n), 32'd1);
        check("k8_din", 32'(sdm_din), 32'h155);
        check("k8_pulse", 32'(upd_pulse), 32'd1);
        check("k8_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        check("k8_state", 32'(state), 32'd2);
        check("k8_ready", 32'(cfg_ready), 32'd1);
        tick();
        check("k9_pulse", 32'(upd_pulse), 32'd0);
        ticks(2);                                 // edge k+11
        check("k11_valid", 32'(sdm_out_valid), 32'd0);
        tick();                                   // edge k+12
        check("k12_valid", 32'(sdm_out_valid), 32'd1);
        check("k12_state", 32'(state), 32'd3);

        // RUN update with 0x3FF
        offer(10'h3FF);
        check("run_acc_ready", 32'(cfg_ready), 32'd0);
        check("run_acc_din", 32'(sdm_din), 32'h155);
        check("run_acc_pulse", 32'(upd_pulse), 32'd0);
        tick();
        exp_cnt = exp_cnt + 8'd1;
        check("run_app_din", 32'(sdm_din), 32'h3FF);
        check("run_app_pulse", 32'(upd_pulse), 32'd1);
        check("run_app_ready", 32'(cfg_ready), 32'd1);
        check("run_app_valid", 32'(sdm_out_valid), 32'd1);
        check("run_app_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        tick();
        check("run_post_pulse", 32'(upd_pulse), 32'd0);
        check("run_post_valid", 32'(sdm_out_valid), 32'd1);

        // Streaming: cfg_valid held high, data increments every cycle
        n_acc = 0;
        n_app = 0;
        cfg_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cfg_frac = 10'h100 + 10'(i);
            check("strm_ready", 32'(cfg_ready), 32'((i % 2) == 0));
            if ((i % 2) == 0) begin
                exp_q.push_back(cfg_frac);
                n_acc++;
            end
            tick();
            if ((i % 2) == 1) begin
                exp_word = exp_q.pop_front();
                exp_cnt  = exp_cnt + 8'd1;
                n_app++;
                check("strm_pulse", 32'(upd_pulse), 32'd1);
                check("strm_din", 32'(sdm_din), 32'(exp_word));
            end else begin
                check("strm_nopulse", 32'(upd_pulse), 32'd0);
            end
        end
        cfg_valid = 1'b0;
        check("strm_acc", 32'(n_acc), 32'd6);
        check("strm_app", 32'(n_app), 32'd6);
        check("strm_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        check("strm_last", 32'(sdm_din), 32'h10A);

        // Disable during FLUSH (cnt=3) with 0x0AA pending
        en = 1'b0;
        tick();
        check("dis_state", 32'(state), 32'd0);
        check("dis_clr_n", 32'(sdm_clr_n), 32'd0);
        check("dis_din", 32'(sdm_din), 32'd0);
        check("dis_valid", 32'(sdm_out_valid), 32'd0);
        offer(10'h0AA);
        en = 1'b1;
        ticks(5);                                 // edge k+4 -> cnt=3 in FLUSH
        check("fl3_state", 32'(state), 32'd1);
        en = 1'b0;
        tick();
        check("fl_dis_state", 32'(state), 32'd0);
        check("fl_dis_clr_n", 32'(sdm_clr_n), 32'd0);
        check("fl_dis_ready", 32'(cfg_ready), 32'd0);
        check("fl_dis_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        en = 1'b1;
        ticks(8);                                 // re-enable: k'+7
        check("re7_clr_n", 32'(sdm_clr_n), 32'd0);
        tick();                                   // k'+8
        exp_cnt = exp_cnt + 8'd1;
        check("re8_din", 32'(sdm_din), 32'h0AA);
        check("re8_clr_n", 32'(sdm_clr_n), 32'd1);
        check("re8_pulse", 32'(upd_pulse), 32'd1);
        check("re8_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        ticks(3);
        check("re11_valid", 32'(sdm_out_valid), 32'd0);
        tick();
        check("re12_valid", 32'(sdm_out_valid), 32'd1);

        // en=0 on the same edge as a RUN apply: disable wins, word stays pending
        offer(10'h2AA);
        en = 1'b0;
        tick();
        check("coll_state", 32'(state), 32'd0);
        check("coll_pulse", 32'(upd_pulse), 32'd0);
        check("coll_din", 32'(sdm_din), 32'd0);
        check("coll_ready", 32'(cfg_ready), 32'd0);
        check("coll_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        en = 1'b1;
        ticks(9);
        exp_cnt = exp_cnt + 8'd1;
        check("coll_re_din", 32'(sdm_din), 32'h2AA);
        check("coll_re_updcnt", 32'(upd_cnt), 32'(exp_cnt));
        ticks(4);
        check("coll_re_state", 32'(state), 32'd3);

        // Asynchronous reset mid-cycle in RUN, right after an apply
        offer(10'h033);
        tick();
        check("pre_rst_pulse", 32'(upd_pulse), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_pulse", 32'(upd_pulse), 32'd0);
        check("arst_din", 32'(sdm_din), 32'd0);
        check("arst_clr_n", 32'(sdm_clr_n), 32'd0);
        check("arst_valid", 32'(sdm_out_valid), 32'd0);
        check("arst_updcnt", 32'(upd_cnt), 32'd0);
        check("arst_ready", 32'(cfg_ready), 32'd1);
        en   = 1'b0;
        rstn = 1'b1;
        exp_cnt = 8'd0;
        tick();

        // 256 applied updates wrap upd_cnt; an en toggle midway leaves it alone
        en = 1'b1;
        ticks(13);
        check("wrap_run", 32'(state), 32'd3);
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                en = 1'b0;
                tick();
                check("tog_updcnt_off", 32'(upd_cnt), 32'(exp_cnt));
                en = 1'b1;
                ticks(13);
                check("tog_updcnt_on", 32'(upd_cnt), 32'(exp_cnt));
                check("tog_state", 32'(state), 32'd3);
            end
            offer(10'(i));
            tick();
            exp_cnt = exp_cnt + 8'd1;
            if (i == 254) check("wrap_255", 32'(upd_cnt), 32'd255);
            if (i == 200) check("wrap_din200", 32'(sdm_din), 32'd200);
        end
        check("wrap_0", 32'(upd_cnt), 32'd0);
        check("wrap_din", 32'(sdm_din), 32'h0FF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
